// File: rtl/dmem_stream_reader.sv
// Streams a run of consecutive 32-bit words out of the 4-bank byte-wide data memory
// onto a valid/ready interface. CPU accesses win the bank port; a small FIFO absorbs backpressure.
module dmem_stream_reader #(
    parameter int ADDRW = 13,
    parameter int CNTW  = 16,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDRW+1:0]   base_addr,
    input  logic [CNTW-1:0]    word_count,
    output logic               busy,
    output logic               done,
    input  logic               cpu_mem_busy,
    output logic [ADDRW-1:0]   bank_addr,
    output logic               bank_rden,
    input  logic [31:0]        bank_dout,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [31:0]        m_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDRW-1:0]  row_r;
    logic [CNTW-1:0]   remaining_r;
    logic              pend_r;
    logic [31:0]       pend_data_r;
    logic [31:0]       fifo_mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW:0]       count_r;
    logic              fire_s;
    logic              push_s;
    logic              pop_s;
    logic              accept_s;
    logic              unused_s;

    // The two byte-offset bits of the start address carry no information for word reads.
    assign unused_s = ^base_addr[1:0];

    // Read issue: reserve a FIFO slot for the word already in flight before firing another.
    always_comb begin
        fire_s = 1'b0;
        if ((state_r == RUN) && (remaining_r != '0) && !cpu_mem_busy &&
            ((count_r + {{PW{1'b0}}, pend_r}) < DEPTH_C)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    assign accept_s = (state_r == IDLE) && start;
    assign push_s   = pend_r;
    assign pop_s    = (count_r != '0) && m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DRAIN finishes in the cycle that pops the last queued word.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = (word_count != '0) ? RUN : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (remaining_r == '0) begin
                    state_s = DRAIN;
                end else if (fire_s && (remaining_r == CNTW'(1))) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (!pend_r && ((count_r == '0) || ((count_r == (PW+1)'(1)) && pop_s))) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                done = 1'b0;
            end
            RUN, DRAIN: begin
                busy = 1'b1;
                done = 1'b0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Row pointer and remaining count; row wraps naturally at the bank size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r       <= '0;
            remaining_r <= '0;
        end else if (accept_s) begin
            row_r       <= base_addr[ADDRW+1:2];
            remaining_r <= word_count;
        end else if (fire_s) begin
            row_r       <= row_r + ADDRW'(1);
            remaining_r <= remaining_r - CNTW'(1);
        end
    end

    // Capture stage: the bank updated Data_Out on the negedge of the fired cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r      <= 1'b0;
            pend_data_r <= 32'h0000_0000;
        end else begin
            pend_r <= fire_s;
            if (fire_s) begin
                pend_data_r <= bank_dout;
            end
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= pend_data_r;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
        end
    end

    // FIFO occupancy; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign bank_addr = row_r;
    assign bank_rden = fire_s;
    assign m_valid   = (count_r != '0);
    assign m_data    = fifo_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Randomized self-checking bench for dmem_stream_reader: a bank memory model plus a
// word-sequence scoreboard derived from base row, word count and memory contents.
module tb_dmem_stream_reader;

    localparam int ADDRW = 13;
    localparam int CNTW  = 16;
    localparam int DEPTH = 4;
    localparam int ROWS  = 1 << ADDRW;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [ADDRW+1:0]   base_addr;
    logic [CNTW-1:0]    word_count;
    logic               busy;
    logic               done;
    logic               cpu_mem_busy;
    logic [ADDRW-1:0]   bank_addr;
    logic               bank_rden;
    logic [31:0]        bank_dout;
    logic               m_valid;
    logic               m_ready;
    logic [31:0]        m_data;

    dmem_stream_reader #(.ADDRW(ADDRW), .CNTW(CNTW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .done         (done),
        .cpu_mem_busy (cpu_mem_busy),
        .bank_addr    (bank_addr),
        .bank_rden    (bank_rden),
        .bank_dout    (bank_dout),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data)
    );

    logic [31:0] mem [ROWS];
    logic [31:0] exp_q [$];
    int          addr_log [$];
    int          total;
    int          bad;
    int          cyc;
    int          issue_row;
    int          issued;
    int          popped;
    int          last_pop_cyc;
    bit          mon_en;
    bit          prev_hold;
    logic [31:0] prev_data;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Bank model: sample address/enable on negedge, update Data_Out on the same negedge.
    initial begin
        bank_dout = 32'h0;
        forever begin
            @(negedge clk);
            if (bank_rden === 1'b1) bank_dout = mem[bank_addr];
        end
    end

    // Monitor: read addresses, CPU exclusion, FIFO bound, output word order and hold.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bank_rden === 1'b1) begin
                    chk_eq("cpu_excl", 32'(cpu_mem_busy), 32'd0);
                    chk_eq("rd_addr", 32'(bank_addr), 32'(issue_row % ROWS));
                    addr_log.push_back(int'(bank_addr));
                    issue_row++;
                    issued++;
                    chk_eq("inflight_bound", 32'((issued - popped) <= DEPTH), 32'd1);
                end
                if (prev_hold) chk_eq("hold_data", m_data, prev_data);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) chk_eq("extra_word", m_data, 32'hDEAD_BEEF);
                    else chk_eq("word", m_data, exp_q.pop_front());
                    popped++;
                    last_pop_cyc = cyc;
                end
                prev_hold = m_valid && !m_ready;
                prev_data = m_data;
            end
        end
    end

    task automatic start_run(input int row, input int n);
        logic [ADDRW-1:0] r;
        r = row[ADDRW-1:0];
        @(posedge clk);
        #1;
        issue_row = row;
        issued    = 0;
        popped    = 0;
        addr_log.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mem[(row + i) % ROWS]);
        start      = 1'b1;
        base_addr  = {r, 2'($urandom_range(0, 3))};
        word_count = n[CNTW-1:0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input bit rnd, input int n);
        bit seen;
        int done_cyc;
        seen     = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < maxc; i++) begin
            if (rnd) begin
                @(posedge clk);
                #1;
                m_ready      = ($urandom_range(0, 3) != 0);
                cpu_mem_busy = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                break;
            end
        end
        chk_eq("done_seen", 32'(seen), 32'd1);
        if (seen && n > 0) chk_eq("done_after_pop", 32'(done_cyc - last_pop_cyc), 32'd1);
        chk_eq("reads_issued", 32'(issued), 32'(n));
        chk_eq("words_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        m_ready      = 1'b1;
        cpu_mem_busy = 1'b0;
        @(negedge clk);
        chk_eq("busy_after_done", 32'(busy), 32'd0);
        chk_eq("done_once", 32'(done), 32'd0);
    endtask

    initial begin
        int wrap_exp [4];
        wrap_exp = '{8190, 8191, 0, 1};
        total = 0; bad = 0; issued = 0; popped = 0; issue_row = 0; last_pop_cyc = 0;
        mon_en = 1'b0; prev_hold = 1'b0; prev_data = 32'h0;
        for (int r = 0; r < ROWS; r++) mem[r] = 32'hA000_0000 + 32'(r);
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        cpu_mem_busy = 1'b0; m_ready = 1'b1;
        #12;
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_valid", 32'(m_valid), 32'd0);
        chk_eq("rst_data", m_data, 32'd0);
        chk_eq("rst_rden", 32'(bank_rden), 32'd0);
        chk_eq("rst_addr", 32'(bank_addr), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        mon_en = 1'b1;

        // Basic read with latency probe.
        start_run(16, 4);
        @(negedge clk);
        chk_eq("lat_rden_c1", 32'(bank_rden), 32'd1);
        chk_eq("lat_valid_c1", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk_eq("lat_valid_c2", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk_eq("lat_valid_c3", 32'(m_valid), 32'd1);
        chk_eq("lat_first_word", m_data, 32'hA000_0010);
        wait_done(40, 1'b0, 4);

        // Zero count.
        start_run(7, 0);
        @(negedge clk);
        chk_eq("zero_busy", 32'(busy), 32'd1);
        chk_eq("zero_done", 32'(done), 32'd1);
        chk_eq("zero_rden", 32'(bank_rden), 32'd0);
        @(negedge clk);
        chk_eq("zero_busy_end", 32'(busy), 32'd0);
        chk_eq("zero_done_end", 32'(done), 32'd0);
        chk_eq("zero_reads", 32'(issued), 32'd0);

        // Backpressure.
        m_ready = 1'b0;
        start_run(300, 10);
        repeat (8) @(negedge clk);
        chk_eq("bp_reads", 32'(issued), 32'd4);
        chk_eq("bp_rden", 32'(bank_rden), 32'd0);
        chk_eq("bp_valid", 32'(m_valid), 32'd1);
        @(posedge clk); #1; m_ready = 1'b1;
        wait_done(60, 1'b0, 10);

        // CPU conflict in cycles 2-4.
        start_run(200, 6);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1; cpu_mem_busy = 1'b1;
            @(negedge clk);
            chk_eq("cpu_stall", 32'(bank_rden), 32'd0);
        end
        @(posedge clk); #1; cpu_mem_busy = 1'b0;
        wait_done(60, 1'b0, 6);

        // Row wrap.
        start_run(8190, 4);
        wait_done(40, 1'b0, 4);
        chk_eq("wrap_len", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < addr_log.size(); i++) chk_eq("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));

        // Reset during DRAIN with two words queued.
        m_ready = 1'b0;
        start_run(500, 2);
        repeat (5) @(negedge clk);
        chk_eq("pre_rst_valid", 32'(m_valid), 32'd1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_busy", 32'(busy), 32'd0);
        chk_eq("mid_rst_done", 32'(done), 32'd0);
        chk_eq("mid_rst_valid", 32'(m_valid), 32'd0);
        chk_eq("mid_rst_data", m_data, 32'd0);
        chk_eq("mid_rst_rden", 32'(bank_rden), 32'd0);
        chk_eq("mid_rst_addr", 32'(bank_addr), 32'd0);
        exp_q.delete();
        @(posedge clk); #1; rst_n = 1'b1; m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_eq("post_rst_done", 32'(done), 32'd0);
            chk_eq("post_rst_busy", 32'(busy), 32'd0);
        end
        prev_hold = 1'b0;
        mon_en = 1'b1;

        // New run with a start pulse while busy that must be ignored.
        start_run(100, 8);
        @(posedge clk); #1;
        start = 1'b1; base_addr = {13'd5000, 2'b00}; word_count = 16'd3;
        @(posedge clk); #1; start = 1'b0;
        wait_done(60, 1'b0, 8);
        repeat (3) begin
            @(negedge clk);
            chk_eq("no_queued_start", 32'(busy), 32'd0);
        end

        // Randomized runs with random memory, backpressure and CPU conflicts.
        for (int r = 0; r < ROWS; r++) mem[r] = $urandom;
        for (int t = 0; t < 8; t++) begin
            start_run(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(1, 24)));
            wait_done(400, 1'b1, int'(exp_q.size()) + issued);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
